// File: rtl/bit_serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and default word width.
// No logic; imported by the serializer top and its hold buffer.
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/serializer_hold_buffer.sv
// One-entry holding register that parks the next word while the current one shifts out.
// Latency: loaded word visible on o_data the cycle after i_load; backpressure: o_ready low while full or in reset.
module serializer_hold_buffer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_take,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_ready
);

    logic [WIDTH-1:0] r_hreg;
    logic             r_hold_full;

    // Load and take never coincide: a load needs the buffer empty, a take needs it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hreg      <= '0;
            r_hold_full <= 1'b0;
        end else if (i_take) begin
            r_hold_full <= 1'b0;
        end else if (i_load) begin
            r_hreg      <= i_data;
            r_hold_full <= 1'b1;
        end
    end

    assign o_data  = r_hreg;
    assign o_full  = r_hold_full;
    assign o_ready = !r_hold_full && !rst;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, one bit per clock; optional parity bit via BIT_SERIALIZER_PARITY_EN.
// Latency: MSB on ser_data right after the accepting edge; back-to-back words stream with no gap.
// Backpressure: in_ready drops while a word is held, until the current word's end-of-word edge.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int                BCNT_W   = $clog2(WIDTH + 1);
    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [BCNT_W-1:0]  r_bcnt;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic               r_par;
`endif

    logic               w_in_ready;
    logic               w_hold_full;
    logic [WIDTH-1:0]   w_hreg;
    logic               w_accept;
    logic               w_eow;
    logic               w_start;
    logic               w_load_hold;
    logic               w_take;
    logic [WIDTH-1:0]   w_next_word;
    logic               w_bit;

    assign w_accept = in_valid && w_in_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_eow = (r_state == ST_PARITY);
`else
    assign w_eow = (r_state == ST_SHIFT) && (r_bcnt == '0);
`endif

    // A new word starts from IDLE or at end-of-word; the held word always wins over the input.
    assign w_start     = ((r_state == ST_IDLE) || w_eow) && (w_hold_full || w_accept);
    assign w_next_word = w_hold_full ? w_hreg : in_data;
    assign w_take      = w_eow && w_hold_full;
    assign w_load_hold = w_accept && (r_state != ST_IDLE) && !w_eow;

    serializer_hold_buffer #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load_hold),
        .i_take  (w_take),
        .i_data  (in_data),
        .o_data  (w_hreg),
        .o_full  (w_hold_full),
        .o_ready (w_in_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_bcnt  <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_start) begin
            r_state <= ST_SHIFT;
            r_sreg  <= w_next_word;
            r_bcnt  <= LAST_IDX;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par   <= ^w_next_word;
`endif
        end else if ((r_state == ST_IDLE) || w_eow) begin
            r_state <= ST_IDLE;
        end else begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
            r_bcnt <= r_bcnt - 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            if (r_bcnt == '0) begin
                r_state <= ST_PARITY;
            end
`endif
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_bit    = (r_state == ST_PARITY) ? r_par : r_sreg[WIDTH-1];
    assign ser_last = (r_state == ST_PARITY);
`else
    assign w_bit    = r_sreg[WIDTH-1];
    assign ser_last = (r_state == ST_SHIFT) && (r_bcnt == '0);
`endif

    assign ser_valid = (r_state != ST_IDLE);
    assign ser_data  = ser_valid && w_bit;
    assign busy      = ser_valid || w_hold_full;
    assign in_ready  = w_in_ready;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed scenarios plus random traffic against a bit-queue reference model.
module tb_bit_serializer;

    localparam int W = 16;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_data;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model: the queue holds every bit still to be emitted; the front is the bit on the line now.
    // Room for a new word exists whenever at most one word's worth of bits remains.
    function automatic logic model_ready();
        return q.size() <= L;
    endfunction

    task automatic push_word(input logic [W-1:0] d);
        ent_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b    = d[i];
            e.last = (i == 0) && (L == W);
            q.push_back(e);
        end
        if (L != W) begin
            e.b    = ^d;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [W-1:0] d);
        logic er;
        logic have;
        ent_t f;
        rst      = r;
        in_valid = v;
        in_data  = d;
        #1;
        er   = !r && model_ready();
        have = (q.size() > 0);
        f    = have ? q[0] : '0;
        chk("in_ready",  in_ready,  er);
        chk("ser_valid", ser_valid, have);
        chk("ser_data",  ser_data,  f.b);
        chk("ser_last",  ser_last,  f.last);
        chk("busy",      busy,      have);
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (have) void'(q.pop_front());
            if (v && er) push_word(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [W-1:0] words [3];
        int           idx;
        logic         acc;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a valid word offered: nothing may be accepted.
        cyc(1'b1, 1'b1, 16'hFFFF);
        cyc(1'b1, 1'b1, 16'hFFFF);

        // Single word.
        cyc(1'b0, 1'b1, 16'b0101101010110101);
        idle(L + 2);

        // Back-to-back: second word parks in the hold register.
        cyc(1'b0, 1'b1, 16'hA5A5);
        cyc(1'b0, 1'b1, 16'h0FF0);
        idle(2 * L + 2);

        // Three words offered continuously, each held until taken.
        words[0] = 16'h1357;
        words[1] = 16'hFACE;
        words[2] = 16'h0246;
        idx = 0;
        for (int c = 0; c < 3 * L + 4; c++) begin
            acc = (idx < 3) && model_ready();
            cyc(1'b0, idx < 3, words[(idx < 3) ? idx : 0]);
            if (acc) idx++;
        end
        chk("three_words_accepted", idx == 3, 1'b1);

        // Mid-word reset with a word held; the held word must vanish.
        cyc(1'b0, 1'b1, 16'hFFFF);
        cyc(1'b0, 1'b1, 16'h1234);
        idle(6);
        cyc(1'b1, 1'b0, '0);
        idle(2);
        cyc(1'b0, 1'b1, 16'h8000);
        idle(L + 2);

        // Parity-sensitive words.
        cyc(1'b0, 1'b1, 16'h0001);
        idle(L + 1);
        cyc(1'b0, 1'b1, 16'h0003);
        idle(L + 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 65, W'($urandom));
        end
        idle(2 * L + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream detector path. Accepts fixed-width words over a valid/ready handshake and emits them MSB-first, one bit per clock, onto a single serial line that feeds the sequence detector's `data_in`. A one-word holding register lets consecutive words stream with no idle cycles between them.

## Interface
- `WIDTH`, default 16: bits per word; legal range is WIDTH >= 2.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, WIDTH: parallel word; bit WIDTH-1 is transmitted first.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a word this cycle.
- `ser_data`, output, 1: serial bit, connected to the detector's `data_in`.
- `ser_valid`, output, 1: `ser_data` carries a real bit.
- `ser_last`, output, 1: current bit is the final bit of its word.
- `busy`, output, 1: the shift register or the hold register is occupied.

## Operation
- A word is accepted on a rising edge where `in_valid && in_ready`.
- Storage:
  - shift register `sreg` (WIDTH bits);
  - bit counter `bcnt` ($clog2(WIDTH+1) bits);
  - hold register `hreg` plus `hold_full` flag.
- `in_ready` = !hold_full && !rst. It is combinational from registered state and does not depend on `in_valid`.
- FSM states:
  - IDLE: when a word is accepted, load it into `sreg`, set `bcnt` = WIDTH-1, and go to SHIFT.
  - SHIFT: each edge shifts `sreg` left by one and decrements `bcnt`. A word accepted here goes into `hreg` and sets `hold_full`.
  - PARITY: present only with the macro enabled; see Configuration.
- End-of-word edge (SHIFT with `bcnt` == 0, or PARITY):
  - If `hold_full`, move `hreg` into `sreg`, clear `hold_full`, and stay in SHIFT. This gives no gap.
  - Else, if a word is accepted on this edge, load it directly into `sreg` and stay in SHIFT.
  - Else, go to IDLE.
- When the hold register transfers on the same edge that a new word is offered, the new word is not accepted: `in_ready` was 0 during that cycle.
- Outputs:
  - `ser_data` = sreg[WIDTH-1] while `ser_valid` is 1, and 0 otherwise.
  - `ser_valid` = (state != IDLE).
  - `ser_last` = SHIFT && bcnt == 0 (without the macro).
  - `busy` = (state != IDLE) || hold_full.
- Reset, including mid-word: on the next edge the FSM goes to IDLE and `sreg`, `hreg`, `bcnt` and `hold_full` clear. Any partial word and any held word are discarded. No bits are emitted after that edge.

## Timing
- Output reset values: `ser_data` 0, `ser_valid` 0, `ser_last` 0, `busy` 0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Latency: a word accepted at edge N drives its MSB on `ser_data` from just after edge N. Bit k is valid in the cycle following edge N+k.
- Throughput: one bit per clock. Back-to-back words produce a contiguous `ser_valid`.
- Maximum in flight: one word shifting plus one held. A third word sees `in_ready` = 0 until the end-of-word edge of the first.

## Configuration
- `BIT_SERIALIZER_PARITY_EN` defined:
  - after bit 0 of each word, the FSM enters PARITY for one cycle;
  - `ser_data` in that cycle is the even-parity bit (XOR of the word), with `ser_valid` = 1;
  - `ser_last` moves from bit 0 to the parity cycle;
  - each word takes WIDTH+1 cycles.
- Not defined: the PARITY state and the parity register are absent, and each word takes exactly WIDTH cycles.

## Structure
- Package `bit_serializer_pkg`: the state enum (IDLE, SHIFT, PARITY) and a `DEFAULT_WIDTH` = 16 constant.
- Sub-module `serializer_hold_buffer`: the one-entry hold register. It owns `hreg`, `hold_full` and `in_ready`, and exposes load/take strobes. The top level holds the FSM, `sreg` and `bcnt`.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `in_valid` = 1 -> `in_ready` = 0, `ser_valid` = 0, nothing accepted. After release, `in_ready` = 1.
- Single word 16'b0101101010110101 accepted at edge N -> `ser_data` reads 0,1,0,1,1,0,1,0,1,0,1,1,0,1,0,1 in cycles N..N+15. `ser_last` is high only on the 16th bit, and `ser_valid` = 0 afterwards. With the detector attached, `detected` pulses match a reference model.
- Back-to-back: 16'hA5A5 then 16'h0FF0 on consecutive cycles -> second word goes to hold, `in_ready` = 0 for 15 cycles, then 32 contiguous `ser_valid` bits with no gap.
- Backpressure: three words offered continuously -> third accepted only on the cycle after the first word's end-of-word edge. `busy` stays 1 throughout all 48 bits.
- Mid-word reset: `rst` pulsed at bit 7 of 16'hFFFF with a word held -> `ser_valid` = 0 after that edge and the held word is dropped. The next accepted word 16'h8000 starts with bit 1.
- Parity (macro on): 16'h0001 -> 17 bits, last bit 1, `ser_last` on the 17th bit. 16'h0003 -> final bit 0. With the macro off, 16'h0001 gives exactly 16 bits.
